// File: rtl/lfsr_pkg.sv
// Shared constants and pure helper functions for the LFSR bank.
// Helpers work on 64-bit containers and mask down to the requested width,
// so they can be evaluated in constant (parameter) context as well as in logic.
package lfsr_pkg;

  // x^32 + x^22 + x^2 + x + 1, maximal length for a 32-bit register
  localparam logic [31:0] DEFAULT_TAPS = 32'h8020_0003;

  // Golden-ratio increment that spreads reset seeds of neighbouring channels
  localparam logic [31:0] GOLDEN = 32'h9E37_79B9;

  // All-ones mask covering the low width bits
  function automatic logic [63:0] width_mask(input int width);
    if (width >= 64) return '1;
    return (64'd1 << width) - 64'd1;
  endfunction

  // Reset seed of channel c; an all-zero seed would lock the register up,
  // so it is replaced by 1
  function automatic logic [63:0] seed_for(input logic [63:0] base, input int c,
                                           input int width);
    logic [63:0] s;
    s = (base + 64'(c) * 64'(GOLDEN)) & width_mask(width);
    if (s == '0) s = 64'd1;
    return s;
  endfunction

  // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0
  function automatic logic [63:0] lfsr_next(input logic [63:0] state,
                                            input logic [63:0] taps,
                                            input int width);
    logic fb;
    fb = ^(state & taps);
    return ((state << 1) | 64'(fb)) & width_mask(width);
  endfunction

endpackage

// File: rtl/lfsr_channel.sv
// One independent LFSR generator: state register, step/load/lockup logic and
// the output valid flag.
//
// Handshake: a word is transferred at a rising edge where valid & ready are
// both high; the state then advances one step and the next word is visible
// the following cycle. valid never depends on ready. A load on the same edge
// takes priority: the presented word still counts as consumed, but the state
// becomes the loaded seed instead of stepping.
module lfsr_channel
  import lfsr_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;

  // Candidate next values: one LFSR step, and the seed with zero replaced by 1
  always_comb begin
    step_val = WIDTH'(lfsr_next(64'(state), 64'(TAPS), WIDTH));
    load_val = (load_data == '0) ? WIDTH'(1) : load_data;
  end

  // State update: load beats lockup recovery, lockup recovery beats a draw
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RESET_SEED;
      valid <= 1'b0;
    end else begin
      valid <= 1'b1;
      if (load) begin
        state <= load_val;
      end else if (state == '0) begin
        state <= WIDTH'(1);
      end else if (valid && ready) begin
        state <= step_val;
      end
    end
  end

  assign data = state;

endmodule

// File: rtl/lfsr_bank.sv
// Bank of CHANNELS independent LFSR generators. Decodes the seed target
// channel and packs the per-channel state registers onto out_data.
// All outputs come straight from registers inside the channels.
module lfsr_bank
  import lfsr_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          CHANNELS  = 4,
  parameter logic [31:0] TAPS      = DEFAULT_TAPS,
  parameter logic [31:0] SEED_BASE = 32'h1
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          seed_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] seed_ch,
  input  logic [WIDTH-1:0]                              seed_data,
  output logic [CHANNELS-1:0]                           out_valid,
  input  logic [CHANNELS-1:0]                           out_ready,
  output logic [CHANNELS*WIDTH-1:0]                     out_data
);

  localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [CHW-1:0]   SEL  = CHW'(c);
    localparam logic [WIDTH-1:0] SEED = WIDTH'(seed_for(64'(SEED_BASE), c, WIDTH));

    // seed_ch values at or above CHANNELS never match any SEL and are ignored
    logic load_c;
    assign load_c = seed_valid && (seed_ch == SEL);

    lfsr_channel #(
      .WIDTH     (WIDTH),
      .TAPS      (TAPS[WIDTH-1:0]),
      .RESET_SEED(SEED)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .load     (load_c),
      .load_data(seed_data),
      .ready    (out_ready[c]),
      .valid    (out_valid[c]),
      .data     (out_data[c*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// Bench for lfsr_bank: default 4x32 bank plus an 8-bit single-channel bank
// used for the full-period property.
module tb_lfsr_bank;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        seed_valid;
  logic [1:0]  seed_ch;
  logic [31:0] seed_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [127:0] out_data;

  logic        reset8;
  logic        seed_valid8;
  logic [0:0]  seed_ch8;
  logic [7:0]  seed_data8;
  logic [0:0]  out_valid8;
  logic [0:0]  out_ready8;
  logic [7:0]  out_data8;

  lfsr_bank dut (
    .clk       (clk),
    .reset     (reset),
    .seed_valid(seed_valid),
    .seed_ch   (seed_ch),
    .seed_data (seed_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  lfsr_bank #(.WIDTH(8), .CHANNELS(1), .TAPS(32'h0000_00B8), .SEED_BASE(32'h1)) dut8 (
    .clk       (clk),
    .reset     (reset8),
    .seed_valid(seed_valid8),
    .seed_ch   (seed_ch8),
    .seed_data (seed_data8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .out_data  (out_data8)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] s_exp [4];
  logic [31:0] exp_q [$];
  logic [3:0]  vexp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [31:0] taps,
                                           input int w);
    logic fb;
    logic [31:0] m;
    fb = 1'b0;
    for (int i = 0; i < w; i++) if (taps[i] && s[i]) fb = ~fb;
    m = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return ((s << 1) | {31'd0, fb}) & m;
  endfunction

  function automatic logic [31:0] ch_word(input logic [127:0] d, input int c);
    return d[c*32 +: 32];
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; out_ready = '0; seed_valid = 1'b0; seed_ch = '0; seed_data = '0;
    repeat (2) @(negedge clk);
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL reset_valid got=%b want=%b", out_valid, 4'b0000);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ch_word(out_data, c) !== s_exp[c]) begin
        bad++; $display("FAIL reset_seed ch%0d got=%h want=%h", c, ch_word(out_data, c), s_exp[c]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 4'b1111) begin
      bad++; $display("FAIL valid_after_reset got=%b want=%b", out_valid, 4'b1111);
    end
    total++;
    if (ch_word(out_data, 0) !== 32'h1) begin
      bad++; $display("FAIL no_draw_first_edge got=%h want=%h", ch_word(out_data, 0), 32'h1);
    end
  endtask

  task automatic test_draw_hold();
    logic [31:0] lit [3];
    logic [31:0] e0;
    lit[0] = 32'h3; lit[1] = 32'h6; lit[2] = 32'hD;
    e0 = 32'h1;
    out_ready = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      e0 = ref_step(e0, 32'h8020_0003, 32);
      if (i < 3) begin
        total++;
        if (ch_word(out_data, 0) !== lit[i]) begin
          bad++; $display("FAIL draw_seq step%0d got=%h want=%h", i, ch_word(out_data, 0), lit[i]);
        end
      end else begin
        total++;
        if (ch_word(out_data, 0) !== e0) begin
          bad++; $display("FAIL draw_model step%0d got=%h want=%h", i, ch_word(out_data, 0), e0);
        end
      end
      total++;
      if (ch_word(out_data, 1) !== 32'h9E37_79BA) begin
        bad++; $display("FAIL hold_ch1 cyc%0d got=%h want=%h", i, ch_word(out_data, 1), 32'h9E37_79BA);
      end
    end
    out_ready = '0;
  endtask

  task automatic test_load();
    logic [31:0] e;
    seed_valid = 1'b1; seed_ch = 2'd2; seed_data = 32'h0;
    @(negedge clk);
    seed_valid = 1'b0;
    total++;
    if (ch_word(out_data, 2) !== 32'h1) begin
      bad++; $display("FAIL load_zero got=%h want=%h", ch_word(out_data, 2), 32'h1);
    end
    seed_valid = 1'b1; seed_data = 32'hDEAD_BEEF; out_ready = 4'b0100;
    @(negedge clk);
    seed_valid = 1'b0;
    total++;
    if (ch_word(out_data, 2) !== 32'hDEAD_BEEF) begin
      bad++; $display("FAIL load_beats_draw got=%h want=%h", ch_word(out_data, 2), 32'hDEAD_BEEF);
    end
    total++;
    if (ch_word(out_data, 3) !== s_exp[3]) begin
      bad++; $display("FAIL load_isolation got=%h want=%h", ch_word(out_data, 3), s_exp[3]);
    end
    e = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      e = ref_step(e, 32'h8020_0003, 32);
      total++;
      if (ch_word(out_data, 2) !== e) begin
        bad++; $display("FAIL step_after_load %0d got=%h want=%h", i, ch_word(out_data, 2), e);
      end
    end
    out_ready = '0;
  endtask

  task automatic test_async_reset();
    out_ready = 4'b1111;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_valid !== 4'b0000) begin
      bad++; $display("FAIL async_valid got=%b want=%b", out_valid, 4'b0000);
    end
    for (int c = 0; c < 4; c++) begin
      total++;
      if (ch_word(out_data, c) !== s_exp[c]) begin
        bad++; $display("FAIL async_seed ch%0d got=%h want=%h", c, ch_word(out_data, c), s_exp[c]);
      end
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid !== 4'b1111 || ch_word(out_data, 0) !== 32'h1) begin
      bad++; $display("FAIL resume_first got=%b/%h want=%b/%h", out_valid, ch_word(out_data, 0), 4'b1111, 32'h1);
    end
    @(negedge clk);
    total++;
    if (ch_word(out_data, 0) !== 32'h3) begin
      bad++; $display("FAIL resume_step got=%h want=%h", ch_word(out_data, 0), 32'h3);
    end
    out_ready = '0;
  endtask

  task automatic test_random();
    logic [31:0] m [4];
    logic [3:0]  mv;
    reset = 1'b1; out_ready = '0; seed_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) m[c] = s_exp[c];
    mv = 4'b0000;
    for (int i = 0; i < 300; i++) begin
      out_ready  = 4'($urandom_range(0, 15));
      seed_valid = ($urandom_range(0, 5) == 0);
      seed_ch    = 2'($urandom_range(0, 3));
      seed_data  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      for (int c = 0; c < 4; c++) begin
        if (seed_valid && seed_ch == 2'(c)) m[c] = (seed_data == 32'h0) ? 32'h1 : seed_data;
        else if (mv[c] && out_ready[c]) m[c] = ref_step(m[c], 32'h8020_0003, 32);
        exp_q.push_back(m[c]);
      end
      mv = 4'b1111;
      vexp_q.push_back(mv);
      @(negedge clk);
      total++;
      if (vexp_q.size() == 0) begin
        bad++; $display("FAIL rand_valid cyc%0d got=%b want=queued", i, out_valid);
      end else begin
        logic [3:0] ev;
        ev = vexp_q.pop_front();
        if (out_valid !== ev) begin
          bad++; $display("FAIL rand_valid cyc%0d got=%b want=%b", i, out_valid, ev);
        end
      end
      for (int c = 0; c < 4; c++) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rand_data cyc%0d ch%0d got=%h want=queued", i, c, ch_word(out_data, c));
        end else begin
          logic [31:0] ew;
          ew = exp_q.pop_front();
          if (ch_word(out_data, c) !== ew) begin
            bad++; $display("FAIL rand_data cyc%0d ch%0d got=%h want=%h", i, c, ch_word(out_data, c), ew);
          end
        end
      end
    end
    seed_valid = 1'b0; out_ready = '0;
  endtask

  task automatic test_period8();
    logic [255:0] seen;
    logic [31:0]  e;
    int           cnt;
    reset8 = 1'b1; out_ready8 = 1'b0; seed_valid8 = 1'b0; seed_ch8 = '0; seed_data8 = '0;
    @(negedge clk);
    reset8 = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid8 !== 1'b1 || out_data8 !== 8'h01) begin
      bad++; $display("FAIL p8_start got=%b/%h want=%b/%h", out_valid8, out_data8, 1'b1, 8'h01);
    end
    seen = '0; e = 32'h1;
    out_ready8 = 1'b1;
    for (int i = 0; i < 255; i++) begin
      total++;
      if (out_data8 === 8'h00 || seen[out_data8]) begin
        bad++; $display("FAIL p8_unique step%0d got=%h want=new_nonzero", i, out_data8);
      end else begin
        seen[out_data8] = 1'b1;
      end
      total++;
      if (out_data8 !== e[7:0]) begin
        bad++; $display("FAIL p8_model step%0d got=%h want=%h", i, out_data8, e[7:0]);
      end
      e = ref_step(e, 32'h0000_00B8, 8);
      @(negedge clk);
    end
    total++;
    if (out_data8 !== 8'h01) begin
      bad++; $display("FAIL p8_wrap got=%h want=%h", out_data8, 8'h01);
    end
    cnt = 0;
    for (int v = 0; v < 256; v++) if (seen[v]) cnt++;
    total++;
    if (cnt != 255) begin
      bad++; $display("FAIL p8_coverage got=%0d want=%0d", cnt, 255);
    end
    out_ready8 = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    s_exp[0] = 32'h0000_0001;
    s_exp[1] = 32'h9E37_79BA;
    s_exp[2] = 32'h3C6E_F373;
    s_exp[3] = 32'hDAA6_6D2C;
    reset8 = 1'b1; out_ready8 = 1'b0; seed_valid8 = 1'b0; seed_ch8 = '0; seed_data8 = '0;
    test_reset();
    test_draw_hold();
    test_load();
    test_async_reset();
    test_random();
    test_period8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
